// File: rtl/l2_rr_arbiter.sv
// Round-robin arbiter sharing one L2 port between I-cache and D-cache.
// The winning command is latched at grant; a sticky watchdog flags stalled L2 transactions.
module l2_rr_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  icache_address,
  input  logic         icache_read,
  input  logic         icache_write,
  input  logic [127:0] icache_wdata,
  output logic [127:0] icache_rdata,
  output logic         icache_mem_resp,
  input  logic [15:0]  dcache_address,
  input  logic         dcache_read,
  input  logic         dcache_write,
  input  logic [127:0] dcache_wdata,
  output logic [127:0] dcache_rdata,
  output logic         dcache_mem_resp,
  input  logic [127:0] l2_rdata,
  input  logic         l2_mem_resp,
  output logic [15:0]  l2_address,
  output logic [127:0] l2_wdata,
  output logic         l2_read,
  output logic         l2_write,
  output logic         last_grant,
  output logic         timeout_err
);

  // state   | meaning
  // IDLE    | no transaction, arbitrate pending requests
  // GRANT_I | I-cache transaction in flight on L2
  // GRANT_D | D-cache transaction in flight on L2
  // RELEASE | one dead cycle so the requester can drop its request
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;

  state_t       state_q;
  logic         last_q;
  logic [7:0]   cnt_q;
  logic [7:0]   cnt_d;
  logic         err_q;
  logic [15:0]  addr_q;
  logic [127:0] wdata_q;
  logic         rd_q;
  logic         wr_q;
  logic         req_i;
  logic         req_d;
  logic         pick_i;

  assign req_i  = icache_read | icache_write;
  assign req_d  = dcache_read | dcache_write;
  // On a tie the requester that was not granted last wins.
  assign pick_i = req_i & (~req_d | last_q);

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
      addr_q  <= 16'd0;
      wdata_q <= 128'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_i) begin
            addr_q  <= icache_address;
            wdata_q <= icache_wdata;
            rd_q    <= icache_read & ~icache_write;
            wr_q    <= icache_write;
            last_q  <= 1'b0;
            cnt_q   <= 8'd0;
            state_q <= GRANT_I;
          end else if (req_d) begin
            addr_q  <= dcache_address;
            wdata_q <= dcache_wdata;
            rd_q    <= dcache_read & ~dcache_write;
            wr_q    <= dcache_write;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
            state_q <= GRANT_D;
          end
        end
        GRANT_I, GRANT_D: begin
          if (l2_mem_resp) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            state_q <= RELEASE;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == 8'(TIMEOUT_CYCLES)) err_q <= 1'b1;
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign l2_address      = addr_q;
  assign l2_wdata        = wdata_q;
  assign l2_read         = rd_q;
  assign l2_write        = wr_q;
  assign last_grant      = last_q;
  assign timeout_err     = err_q;
  assign icache_mem_resp = (state_q == GRANT_I) & l2_mem_resp;
  assign dcache_mem_resp = (state_q == GRANT_D) & l2_mem_resp;
  assign icache_rdata    = (state_q == GRANT_I) ? l2_rdata : 128'd0;
  assign dcache_rdata    = (state_q == GRANT_D) ? l2_rdata : 128'd0;

endmodule

// File: tb/tb_l2_rr_arbiter.sv
// Directed bench for l2_rr_arbiter with hand-computed expectations.
module tb_l2_rr_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  icache_address, dcache_address;
  logic         icache_read, icache_write, dcache_read, dcache_write;
  logic [127:0] icache_wdata, dcache_wdata, icache_rdata, dcache_rdata;
  logic         icache_mem_resp, dcache_mem_resp;
  logic [127:0] l2_rdata, l2_wdata;
  logic         l2_mem_resp, l2_read, l2_write, last_grant, timeout_err;
  logic [15:0]  l2_address;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [127:0] RD_A5 = {16{8'hA5}};
  localparam logic [127:0] WD_DB = {4{32'hDEADBEEF}};
  localparam logic [127:0] RD_5A = {16{8'h5A}};

  l2_rr_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .icache_address(icache_address), .icache_read(icache_read),
    .icache_write(icache_write), .icache_wdata(icache_wdata),
    .icache_rdata(icache_rdata), .icache_mem_resp(icache_mem_resp),
    .dcache_address(dcache_address), .dcache_read(dcache_read),
    .dcache_write(dcache_write), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata), .dcache_mem_resp(dcache_mem_resp),
    .l2_rdata(l2_rdata), .l2_mem_resp(l2_mem_resp),
    .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_read(l2_read), .l2_write(l2_write),
    .last_grant(last_grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    icache_address = '0; icache_read = 0; icache_write = 0; icache_wdata = '0;
    dcache_address = '0; dcache_read = 0; dcache_write = 0; dcache_wdata = '0;
    l2_rdata = '0; l2_mem_resp = 0;
    do_reset();

    check("rst_l2_read", l2_read, 0);
    check("rst_l2_write", l2_write, 0);
    check("rst_last_grant", last_grant, 1);
    check("rst_timeout", timeout_err, 0);
    check("rst_l2_addr", l2_address, 0);

    // single I-cache read, L2 answers in the 4th grant cycle
    icache_read = 1; icache_address = 16'h1230;
    tick();
    icache_read = 0;
    check("t1_l2_read", l2_read, 1);
    check("t1_l2_addr", l2_address, 16'h1230);
    check("t1_last_grant", last_grant, 0);
    check("t1_no_early_resp", icache_mem_resp, 0);
    tick(); tick(); tick();
    l2_mem_resp = 1; l2_rdata = RD_A5;
    #1;
    check("t1_iresp", icache_mem_resp, 1);
    check("t1_irdata", icache_rdata, RD_A5);
    check("t1_dresp", dcache_mem_resp, 0);
    check("t1_drdata", dcache_rdata, 0);
    tick();
    check("t1_rel_read", l2_read, 0);
    check("t1_rel_resp_ignored", icache_mem_resp, 0);
    check("t1_rel_rdata", icache_rdata, 0);
    l2_mem_resp = 0;
    tick();

    // both request continuously: I, D, I, D
    do_reset();
    icache_read = 1; icache_address = 16'h1111;
    dcache_read = 1; dcache_address = 16'h2222;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_addr", l2_address, (k % 2 == 0) ? 16'h1111 : 16'h2222);
      check("rr_read", l2_read, 1);
      check("rr_last_grant", last_grant, (k % 2 == 0) ? 0 : 1);
      tick();
      l2_mem_resp = 1; l2_rdata = RD_5A;
      #1;
      check("rr_iresp", icache_mem_resp, (k % 2 == 0) ? 1 : 0);
      check("rr_dresp", dcache_mem_resp, (k % 2 == 0) ? 0 : 1);
      tick();
      check("rr_gap_read", l2_read, 0);
      check("rr_gap_write", l2_write, 0);
      l2_mem_resp = 0;
      tick();
      check("rr_idle_read", l2_read, 0);
    end
    icache_read = 0; dcache_read = 0;

    // D-cache write, requester changes inputs mid-transaction
    dcache_write = 1; dcache_address = 16'h0040; dcache_wdata = WD_DB;
    tick();
    dcache_address = 16'h0999; dcache_wdata = '0; dcache_write = 0;
    check("wr_write", l2_write, 1);
    check("wr_read", l2_read, 0);
    tick();
    check("wr_addr_held", l2_address, 16'h0040);
    check("wr_wdata_held", l2_wdata, WD_DB);
    check("wr_write_held", l2_write, 1);
    l2_mem_resp = 1;
    #1;
    check("wr_dresp", dcache_mem_resp, 1);
    check("wr_iresp", icache_mem_resp, 0);
    tick();
    l2_mem_resp = 0;
    check("wr_rel_write", l2_write, 0);
    tick();

    // simultaneous read and write is a write; earliest response
    dcache_read = 1; dcache_write = 1; dcache_address = 16'h0050;
    tick();
    dcache_read = 0; dcache_write = 0;
    check("rw_write", l2_write, 1);
    check("rw_read", l2_read, 0);
    l2_mem_resp = 1;
    #1;
    check("rw_dresp", dcache_mem_resp, 1);
    tick();
    l2_mem_resp = 0;
    tick();

    // watchdog with TIMEOUT_CYCLES = 4
    icache_read = 1; icache_address = 16'h0777;
    tick();
    icache_read = 0;
    check("to_grant_read", l2_read, 1);
    check("to_start", timeout_err, 0);
    tick(); tick(); tick();
    check("to_before", timeout_err, 0);
    tick();
    check("to_set", timeout_err, 1);
    check("to_still_waiting", l2_read, 1);
    l2_mem_resp = 1;
    #1;
    check("to_late_iresp", icache_mem_resp, 1);
    tick();
    l2_mem_resp = 0;
    tick();
    check("to_sticky", timeout_err, 1);

    // reset during GRANT_D
    dcache_read = 1; dcache_address = 16'h0123;
    tick();
    check("rg_read", l2_read, 1);
    check("rg_last_grant", last_grant, 1);
    rst = 1;
    tick();
    rst = 0;
    check("rg_read_cleared", l2_read, 0);
    check("rg_write_cleared", l2_write, 0);
    check("rg_timeout_cleared", timeout_err, 0);
    check("rg_last_grant_rst", last_grant, 1);
    l2_mem_resp = 1;
    #1;
    check("rg_late_dresp", dcache_mem_resp, 0);
    check("rg_late_iresp", icache_mem_resp, 0);
    l2_mem_resp = 0;
    icache_read = 1; icache_address = 16'h0AAA;
    tick();
    check("rg_first_i_addr", l2_address, 16'h0AAA);
    check("rg_first_i_grant", last_grant, 0);
    icache_read = 0; dcache_read = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/l2_rr_arbiter.md
Name: l2_rr_arbiter

Overview:
- Round-robin arbiter that shares the single L2 cache port between the instruction cache and the data cache.
- Captures the winning requester's address, write data and command into registers at grant. The L2 interface is therefore glitch-free and independent of requester behaviour during the transaction.
- Routes the L2 response back to the granted requester only.
- Provides a sticky watchdog flag for L2 transactions that never complete.

Parameters:
TIMEOUT_CYCLES, 255, cycles in a grant state without l2_mem_resp before timeout_err sets (1..255; counter is 8 bits)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
icache_address  in  16  I-cache line address
icache_read  in  1  I-cache read request
icache_write  in  1  I-cache write request
icache_wdata  in  128  I-cache write line
icache_rdata  out  128  line returned to I-cache
icache_mem_resp  out  1  I-cache transaction done
dcache_address  in  16  D-cache line address
dcache_read  in  1  D-cache read request
dcache_write  in  1  D-cache write request
dcache_wdata  in  128  D-cache write line
dcache_rdata  out  128  line returned to D-cache
dcache_mem_resp  out  1  D-cache transaction done
l2_rdata  in  128  L2 read line
l2_mem_resp  in  1  L2 transaction done
l2_address  out  16  registered address to L2
l2_wdata  out  128  registered write line to L2
l2_read  out  1  registered read command
l2_write  out  1  registered write command
last_grant  out  1  0 = I-cache granted last, 1 = D-cache granted last
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Request definitions: req_i = icache_read | icache_write; req_d = dcache_read | dcache_write.
- States: IDLE, GRANT_I, GRANT_D, RELEASE.
- Reset (rst = 1 at an edge):
  - state = IDLE, last_grant = 1 (so I-cache wins the first tie), timeout counter = 0, timeout_err = 0.
  - Latched address, wdata, read and write registers = 0.
  - Reset applies mid-transaction too: the transaction is aborted and l2_read/l2_write are 0 from the next cycle.
- IDLE:
  - Only req_i: grant I-cache. Only req_d: grant D-cache.
  - Both: grant the requester other than last_grant.
  - No request: stay in IDLE.
- On grant (same edge):
  - Latch the winner's address and wdata.
  - Latch read = rd & ~wr and write = wr. A simultaneous read and write is treated as a write.
  - Set last_grant to the winner, clear the counter, and move to GRANT_I or GRANT_D.
- GRANT_x:
  - l2_address, l2_wdata, l2_read and l2_write come from the latch registers only.
  - Combinational response routing:
    - Granted requester: x_mem_resp = l2_mem_resp, x_rdata = l2_rdata.
    - Other requester: resp = 0, rdata = 0.
  - On l2_mem_resp = 1: go to RELEASE and clear the l2_read/l2_write latches.
  - Otherwise: stay, and increment the counter (saturating).
  - When the counter equals TIMEOUT_CYCLES, timeout_err sets and holds until rst. The transaction keeps waiting; there is no abort.
- RELEASE:
  - One cycle; l2_read = l2_write = 0 and both mem_resp = 0.
  - No grant is issued in this state.
  - Then go to IDLE. This gives the requester one cycle to drop its request so that a stale request is not re-granted.
- Outside GRANT_x: both mem_resp and both rdata are 0, and l2_mem_resp is ignored.
- Latency:
  - Request present in IDLE at edge N: l2_read/l2_write is high during cycle N+1.
  - The earliest response is in cycle N+1.
  - RELEASE is cycle N+2; IDLE is cycle N+3, where a new grant can be taken.
- A requester that drops or changes its request mid-transaction is ignored. The latched transaction completes and the response is still pulsed to it.
- Fairness: under continuous requests from both caches, grants strictly alternate.

Test Plan:
- Reset, then icache_read = 1 at address 0x1230:
  - l2_read = 1 and l2_address = 0x1230 in the next cycle.
  - L2 responds 3 cycles later with rdata = 0xA5..A5: icache_mem_resp pulses for 1 cycle carrying that data; dcache_mem_resp stays 0; last_grant = 0.
- Both caches request continuously and L2 responds 1 cycle after each command:
  - Grant order is I, D, I, D.
  - l2_address alternates between the two addresses.
  - There is a 1-cycle RELEASE gap with l2_read = l2_write = 0 between transactions.
- dcache_write = 1 at address 0x0040 with wdata = 0xDEAD..BEEF; while the grant is held, change dcache_address and dcache_wdata:
  - l2_address and l2_wdata stay 0x0040 and the original data until the response.
- dcache_read and dcache_write both asserted: l2_write = 1 and l2_read = 0.
- TIMEOUT_CYCLES = 4 and L2 never responds:
  - timeout_err rises on the 4th GRANT cycle and stays high after a later response.
  - timeout_err clears only on rst.
- Assert rst in GRANT_D:
  - Next cycle: state is IDLE and l2_read = l2_write = 0.
  - A late l2_mem_resp produces no cache response.
  - With both caches requesting afterwards, the I-cache is granted first.
